// File: rtl/ppu_affine_pipe.sv
// Per-row affine post-processing for accumulator tiles: sat(round((scale*acc+bias)>>FRAC)),
// optional ReLU, run-time writable scale/bias tables, 2-stage pipeline with backpressure.
module ppu_affine_pipe #(
   parameter int LANES = 16,
   parameter int ACC_W = 24,
   parameter int SC_W  = 16,
   parameter int FRAC  = 10,
   parameter int OUT_W = 18,
   parameter int ROWS  = 16,
   localparam int ROW_W = $clog2(ROWS)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_cfg_we,
   input  logic                     i_cfg_sel,
   input  logic [ROW_W-1:0]         i_cfg_addr,
   input  logic [LANES*SC_W-1:0]    i_cfg_data,
   input  logic                     i_start,
   input  logic                     i_relu_en,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [LANES*ACC_W-1:0]   i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [LANES*OUT_W-1:0]   o_data,
   output logic                     o_last,
   output logic                     o_sat_flag,
   output logic                     o_tile_done,
   output logic [1:0]               o_state
);

   localparam int SW = ACC_W + SC_W + 1;
   localparam logic [SW:0] HALF = (SW+1)'(1) << (FRAC-1);
   localparam logic [SW:0] MAXM = ((SW+1)'(1) << (OUT_W-1)) - (SW+1)'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

   // Handshake: a beat moves on a port when its valid and ready are both high at the
   // clock edge; both pipeline stages advance together only when adv is high.
   state_t                   state, state_nx;
   logic [LANES*SC_W-1:0]    scale_tbl [ROWS];
   logic [LANES*SC_W-1:0]    bias_tbl  [ROWS];
   logic [ROW_W-1:0]         row_cnt;
   logic                     adv, accept, last_hs;
   logic                     s1_valid, s1_relu, s1_last;
   logic signed [SW-1:0]     s1_sum [LANES];
   logic signed [SW-1:0]     s1_d   [LANES];
   logic [LANES*OUT_W-1:0]   s2_d;
   logic [LANES-1:0]         s2_sat;

   assign adv     = !o_valid || i_ready;
   assign o_ready = adv && (state == RUN);
   assign accept  = i_valid && o_ready;
   assign last_hs = o_valid && i_ready && o_last;
   assign o_state = state;

   function automatic logic [OUT_W:0] post(input logic signed [SW-1:0] s, input logic relu);
      logic signed [SW-1:0] v;
      logic [SW-1:0]        mag;
      logic [SW:0]          m;
      logic [OUT_W-1:0]     mo;
      logic                 sat;
      v   = (relu && (s[SW-1] || (s == '0))) ? '0 : s;
      mag = v[SW-1] ? -v : v;
      m   = ({1'b0, mag} + HALF) >> FRAC;
      sat = (m > MAXM);
      if (sat) m = MAXM;
      mo  = m[OUT_W-1:0];
      return {sat, (v[SW-1] ? -mo : mo)};
   endfunction

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_start) state_nx = RUN;
         RUN:     if (accept && (row_cnt == ROW_W'(ROWS-1))) state_nx = DRAIN;
         DRAIN:   if (last_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int r = 0; r < ROWS; r++) begin
            scale_tbl[r] <= '0;
            bias_tbl[r]  <= '0;
         end
      end else if (state == IDLE && i_cfg_we) begin
         if (i_cfg_sel) bias_tbl[i_cfg_addr]  <= i_cfg_data;
         else           scale_tbl[i_cfg_addr] <= i_cfg_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= IDLE;
         row_cnt     <= '0;
         o_sat_flag  <= 1'b0;
         o_tile_done <= 1'b0;
      end else begin
         state       <= state_nx;
         o_tile_done <= last_hs;
         if (state == IDLE && i_start) begin
            row_cnt    <= '0;
            o_sat_flag <= 1'b0;
         end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
         end
         if (adv && s1_valid && (|s2_sat)) o_sat_flag <= 1'b1;
      end
   end

   // Stage 1: full-precision product plus sign-extended bias, per lane.
   always_comb begin
      logic signed [SC_W-1:0]  sc, bi;
      logic signed [ACC_W-1:0] ac;
      logic signed [SW-2:0]    p;
      sc = '0;
      bi = '0;
      ac = '0;
      p  = '0;
      for (int k = 0; k < LANES; k++) begin
         sc      = scale_tbl[row_cnt][k*SC_W +: SC_W];
         bi      = bias_tbl[row_cnt][k*SC_W +: SC_W];
         ac      = i_data[k*ACC_W +: ACC_W];
         p       = sc * ac;
         s1_d[k] = SW'(p) + SW'(bi);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_valid <= 1'b0;
         s1_relu  <= 1'b0;
         s1_last  <= 1'b0;
         for (int k = 0; k < LANES; k++) s1_sum[k] <= '0;
      end else if (adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_relu <= i_relu_en;
            s1_last <= (row_cnt == ROW_W'(ROWS-1));
            for (int k = 0; k < LANES; k++) s1_sum[k] <= s1_d[k];
         end
      end
   end

   // Stage 2: ReLU, round half away from zero, symmetric saturation.
   always_comb begin
      s2_d   = '0;
      s2_sat = '0;
      for (int k = 0; k < LANES; k++) begin
         {s2_sat[k], s2_d[k*OUT_W +: OUT_W]} = post(s1_sum[k], s1_relu);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_valid <= 1'b0;
         o_last  <= 1'b0;
         o_data  <= '0;
      end else if (adv) begin
         o_valid <= s1_valid;
         o_last  <= s1_valid && s1_last;
         if (s1_valid) o_data <= s2_d;
      end
   end

endmodule

// File: tb/tb_ppu_affine_pipe.sv
// Bench for ppu_affine_pipe: directed vector table, multi-cycle corner sequences and
// randomized tiles checked against an arithmetic reference model.
module tb_ppu_affine_pipe;
   localparam int LANES = 16;
   localparam int ACC_W = 24;
   localparam int SC_W  = 16;
   localparam int FRAC  = 10;
   localparam int OUT_W = 18;
   localparam int ROWS  = 16;
   localparam int ROW_W = 4;
   localparam int EW    = LANES*OUT_W + 1;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   i_cfg_we = 1'b0, i_cfg_sel = 1'b0, i_start = 1'b0, i_relu_en = 1'b0;
   logic                   i_valid = 1'b0, i_ready = 1'b1;
   logic [ROW_W-1:0]       i_cfg_addr = '0;
   logic [LANES*SC_W-1:0]  i_cfg_data = '0;
   logic [LANES*ACC_W-1:0] i_data = '0;
   logic                   o_ready, o_valid, o_last, o_sat_flag, o_tile_done;
   logic [LANES*OUT_W-1:0] o_data;
   logic [1:0]             o_state;

   ppu_affine_pipe dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(i_cfg_we), .i_cfg_sel(i_cfg_sel),
      .i_cfg_addr(i_cfg_addr), .i_cfg_data(i_cfg_data), .i_start(i_start),
      .i_relu_en(i_relu_en), .i_valid(i_valid), .o_ready(o_ready), .i_data(i_data),
      .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_last(o_last),
      .o_sat_flag(o_sat_flag), .o_tile_done(o_tile_done), .o_state(o_state)
   );

   // ---------------- clock / reset / ready pattern ----------------
   always #5 clk = ~clk;

   int cyc = 0, tile_cyc = 0, ready_mode = 0;
   always @(posedge clk) begin
      cyc++;
      tile_cyc++;
      #2;
      case (ready_mode)
         1:       i_ready = ($urandom_range(0, 2) != 0);
         2:       i_ready = !(tile_cyc >= 4 && tile_cyc <= 8);
         default: i_ready = 1'b1;
      endcase
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / model state ----------------
   int            checks = 0, failures = 0;
   logic [EW-1:0] exp_q[$];
   longint        m_scale [ROWS][LANES];
   longint        m_bias  [ROWS][LANES];
   bit            tb_in_tile = 0, m_sat = 0, done_due = 0;
   int            m_row = 0, out_row = 0, done_cnt = 0, acc_cyc0 = -1, lat_cyc0 = -1;
   logic [LANES*OUT_W-1:0] first_row = '0;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_vec(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: out = sat(round_half_away((scale*acc + bias) / 2^FRAC)), ReLU first.
   task automatic model_lane(input longint sc, input longint bi, input longint ac, input bit relu,
                             output logic [OUT_W-1:0] o, output bit sat);
      longint s, m, maxv;
      maxv = (longint'(1) << (OUT_W-1)) - 1;
      s = sc * ac + bi;
      if (relu && s <= 0) s = 0;
      m = (s < 0) ? -s : s;
      m = (m + (longint'(1) << (FRAC-1))) / (longint'(1) << FRAC);
      sat = (m > maxv);
      if (sat) m = maxv;
      o = OUT_W'((s < 0) ? -m : m);
   endtask

   task automatic model_load(input bit sel, input int addr, input logic [LANES*SC_W-1:0] data);
      logic signed [SC_W-1:0] v;
      for (int k = 0; k < LANES; k++) begin
         v = data[k*SC_W +: SC_W];
         if (sel) m_bias[addr][k] = longint'(v);
         else     m_scale[addr][k] = longint'(v);
      end
   endtask

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int k = 0; k < LANES; k++) begin
            m_scale[r][k] = 0;
            m_bias[r][k]  = 0;
         end
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (rst_n) begin
         if (done_due) begin
            check("tile_done_pulse", o_tile_done, 1);
            done_due = 0;
            if (o_tile_done) done_cnt++;
         end else if (o_tile_done) begin
            check("tile_done_spurious", o_tile_done, 0);
         end
         if (o_valid && out_row == 0 && lat_cyc0 < 0) lat_cyc0 = cyc;
         if (o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
               check_vec("unexpected_beat", {o_last, o_data}, '0);
            end else begin
               e = exp_q.pop_front();
               check_vec("out_beat", {o_last, o_data}, e);
            end
            if (out_row == 0) first_row = o_data;
            out_row++;
            if (o_last) begin
               done_due = 1;
               out_row  = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tile_begin();
      tb_in_tile = 1;
      m_row = 0;
      m_sat = 0;
      tile_cyc = 0;
      lat_cyc0 = -1;
      acc_cyc0 = -1;
      out_row = 0;
      check("sat_clear_on_start", o_sat_flag, 0);
   endtask

   task automatic start_tile();
      i_start = 1;
      tick();
      i_start = 0;
      tile_begin();
   endtask

   task automatic cfg_write(input bit sel, input int addr, input logic [LANES*SC_W-1:0] data);
      i_cfg_we = 1;
      i_cfg_sel = sel;
      i_cfg_addr = ROW_W'(addr);
      i_cfg_data = data;
      tick();
      i_cfg_we = 0;
      if (!tb_in_tile) model_load(sel, addr, data);
   endtask

   function automatic logic [LANES*SC_W-1:0] uniform_row(input int val);
      logic [SC_W-1:0] v;
      v = SC_W'(val);
      return {LANES{v}};
   endfunction

   function automatic logic [LANES*SC_W-1:0] random_row();
      logic [LANES*SC_W-1:0] d;
      for (int k = 0; k < LANES; k++) d[k*SC_W +: SC_W] = SC_W'($urandom);
      return d;
   endfunction

   task automatic send_beat(input logic [LANES*ACC_W-1:0] acc, input bit relu);
      bit accepted;
      logic [EW-1:0] e;
      logic [OUT_W-1:0] o;
      logic signed [ACC_W-1:0] a;
      bit sat;
      accepted = 0;
      i_valid = 1;
      i_data = acc;
      i_relu_en = relu;
      for (int t = 0; t < 200 && !accepted; t++) begin
         @(negedge clk);
         if (o_ready) begin
            accepted = 1;
            if (m_row == 0) acc_cyc0 = cyc;
            for (int k = 0; k < LANES; k++) begin
               a = acc[k*ACC_W +: ACC_W];
               model_lane(m_scale[m_row][k], m_bias[m_row][k], longint'(a), relu, o, sat);
               e[k*OUT_W +: OUT_W] = o;
               m_sat = m_sat | sat;
            end
            e[EW-1] = (m_row == ROWS-1);
            exp_q.push_back(e);
            m_row++;
         end
         tick();
      end
      i_valid = 0;
      if (!accepted) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_done();
      int d0;
      d0 = done_cnt;
      for (int t = 0; t < 400 && done_cnt == d0; t++) tick();
      check("tile_done_seen", done_cnt - d0, 1);
      check("sat_flag_end", o_sat_flag, m_sat);
      check("queue_empty", exp_q.size(), 0);
      tb_in_tile = 0;
   endtask

   // acc_mode: 0 all lanes acc_val, 1 full random, 2 small random; relu_mode 2 = random.
   task automatic run_tile(input int acc_mode, input int relu_mode, input int acc_val,
                           input bit gaps, input int intrude_at, input bit do_start);
      logic [LANES*ACC_W-1:0] acc;
      bit relu;
      if (do_start) start_tile();
      for (int r = 0; r < ROWS; r++) begin
         for (int k = 0; k < LANES; k++) begin
            case (acc_mode)
               0:       acc[k*ACC_W +: ACC_W] = ACC_W'(acc_val);
               1:       acc[k*ACC_W +: ACC_W] = ACC_W'($urandom);
               default: acc[k*ACC_W +: ACC_W] = ACC_W'(int'($urandom_range(0, 8191)) - 4096);
            endcase
         end
         relu = (relu_mode == 2) ? bit'($urandom_range(0, 1)) : bit'(relu_mode);
         if (gaps && $urandom_range(0, 3) == 0) tick();
         if (r == intrude_at) begin
            i_cfg_we = 1;
            i_cfg_sel = 1'($urandom_range(0, 1));
            i_cfg_addr = '0;
            i_cfg_data = random_row();
            i_start = 1;
            tick();
            i_cfg_we = 0;
            i_start = 0;
         end
         send_beat(acc, relu);
      end
      wait_done();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int scale;
      int bias;
      int acc;
      bit relu;
      int exp_out;
      bit exp_sat;
   } vec_t;
   vec_t vecs[9];

   initial begin
      model_clear();
      vecs[0] = '{1024,      0,         5, 1'b0,       5, 1'b0};
      vecs[1] = '{1024,      0,        -7, 1'b0,      -7, 1'b0};
      vecs[2] = '{512,       0,         3, 1'b0,       2, 1'b0};
      vecs[3] = '{512,       0,        -3, 1'b0,      -2, 1'b0};
      vecs[4] = '{512,       0,         1, 1'b0,       1, 1'b0};
      vecs[5] = '{32767,     0,   8388607, 1'b0,  131071, 1'b1};
      vecs[6] = '{32767,     0,  -8388607, 1'b0, -131071, 1'b1};
      vecs[7] = '{1024,  -1024,         0, 1'b1,       0, 1'b0};
      vecs[8] = '{1024,  -1024,         0, 1'b0,      -1, 1'b0};

      repeat (3) tick();
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data", o_data, 0);
      rst_n = 1;
      tick();
      check("rst_o_last", o_last, 0);
      check("rst_o_sat_flag", o_sat_flag, 0);
      check("rst_o_tile_done", o_tile_done, 0);
      check("rst_o_ready", o_ready, 0);
      check("rst_state_idle", o_state, 0);

      ready_mode = 0;
      foreach (vecs[i]) begin
         cfg_write(0, 0, uniform_row(vecs[i].scale));
         cfg_write(1, 0, uniform_row(vecs[i].bias));
         run_tile(0, int'(vecs[i].relu), vecs[i].acc, 0, -1, 1);
         check("vec_lane0", int'($signed(first_row[0 +: OUT_W])), vecs[i].exp_out);
         check("vec_lane15", int'($signed(first_row[(LANES-1)*OUT_W +: OUT_W])), vecs[i].exp_out);
         check("vec_sat", o_sat_flag, vecs[i].exp_sat);
         check("vec_latency", lat_cyc0 - acc_cyc0, 2);
      end

      // Stall window of i_ready during a full tile with random tables.
      for (int r = 0; r < ROWS; r++) begin
         cfg_write(0, r, random_row());
         cfg_write(1, r, random_row());
      end
      ready_mode = 2;
      run_tile(2, 2, 0, 0, -1, 1);

      // Same-cycle table write and start: the tile must see the new row.
      ready_mode = 1;
      i_cfg_we = 1;
      i_cfg_sel = 0;
      i_cfg_addr = '0;
      i_cfg_data = uniform_row(2048);
      i_start = 1;
      tick();
      i_cfg_we = 0;
      i_start = 0;
      model_load(0, 0, uniform_row(2048));
      tile_begin();
      run_tile(2, 0, 0, 1, -1, 0);

      // Writes and starts during RUN are ignored.
      run_tile(2, 2, 0, 1, 5, 1);

      // Randomized tiles against the model.
      repeat (3) begin
         for (int r = 0; r < ROWS; r++) begin
            cfg_write(0, r, random_row());
            cfg_write(1, r, random_row());
         end
         run_tile($urandom_range(1, 2), 2, 0, 1, -1, 1);
      end

      // Asynchronous reset in the middle of a tile.
      ready_mode = 0;
      start_tile();
      for (int r = 0; r < 6; r++) send_beat({LANES{ACC_W'(int'($urandom_range(0, 4095)))}}, 0);
      rst_n = 0;
      #1;
      check("midrst_o_valid", o_valid, 0);
      check("midrst_o_data", o_data, 0);
      check("midrst_o_last", o_last, 0);
      check("midrst_o_sat_flag", o_sat_flag, 0);
      check("midrst_o_tile_done", o_tile_done, 0);
      check("midrst_state_idle", o_state, 0);
      exp_q.delete();
      done_due = 0;
      out_row = 0;
      tb_in_tile = 0;
      model_clear();
      tick();
      tick();
      rst_n = 1;
      tick();
      check("postrst_o_valid", o_valid, 0);
      cfg_write(0, 3, random_row());
      ready_mode = 1;
      run_tile(2, 2, 0, 1, -1, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
